// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
package mem_pkg;

   localparam int unsigned DEF_NUM_PORTS       = 2;
   localparam int unsigned DEF_ADDR_W          = 32;
   localparam int unsigned DEF_DATA_W          = 32;
   localparam int unsigned DEF_STRB_W          = DEF_DATA_W / 8;
   localparam int unsigned DEF_MAX_OUTSTANDING = 4;
   localparam int unsigned PORT_ID_W           = (DEF_NUM_PORTS > 1) ? $clog2(DEF_NUM_PORTS) : 1;

   // rr_pick works on a fixed 8-port window; callers zero-extend their valid vector
   localparam int unsigned MAX_PORTS = 8;
   localparam int unsigned PICK_W    = 3;

   typedef logic [PORT_ID_W-1:0] port_id_t;

   typedef struct packed {
      logic [DEF_ADDR_W-1:0] addr;
      logic                  wen;
      logic [DEF_DATA_W-1:0] wdata;
      logic [DEF_STRB_W-1:0] wstrb;
   } mem_req_t;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] rdata;
   } mem_resp_t;

   // First set bit of valid at or after ptr, wrapping modulo n; 0 when none is set
   function automatic logic [PICK_W-1:0] rr_pick(input logic [MAX_PORTS-1:0] valid,
                                                 input logic [PICK_W-1:0]    ptr,
                                                 input int unsigned          n);
      logic [PICK_W-1:0] pick;
      logic              found;
      int unsigned       idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
         idx = (32'(ptr) + i) % n;
         if (i < n && !found && valid[idx[PICK_W-1:0]]) begin
            pick  = PICK_W'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side handshake bundle for mem_arbiter.
interface mem_arbiter_if
   import mem_pkg::*;
#(
   parameter int unsigned NUM_PORTS = DEF_NUM_PORTS,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned DATA_W    = DEF_DATA_W
);
   logic [NUM_PORTS-1:0]            req_valid;
   logic [NUM_PORTS-1:0]            req_ready;
   logic [NUM_PORTS*ADDR_W-1:0]     req_addr;
   logic [NUM_PORTS-1:0]            req_wen;
   logic [NUM_PORTS*DATA_W-1:0]     req_wdata;
   logic [NUM_PORTS*DATA_W/8-1:0]   req_wstrb;
   logic [NUM_PORTS-1:0]            resp_valid;
   logic [DATA_W-1:0]               resp_rdata;

   logic                            mem_req_valid;
   logic                            mem_req_ready;
   logic [ADDR_W-1:0]               mem_req_addr;
   logic                            mem_req_wen;
   logic [DATA_W-1:0]               mem_req_wdata;
   logic [DATA_W/8-1:0]             mem_req_wstrb;
   logic                            mem_resp_valid;
   logic [DATA_W-1:0]               mem_resp_rdata;

   // Arbiter side
   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
      output req_ready, resp_valid, resp_rdata,
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb
   );

   // Requesters plus memory
   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata,
      input  req_ready, resp_valid, resp_rdata,
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb
   );
endinterface

// File: rtl/mem_arbiter_id_fifo.sv
// Synchronous FIFO of requester IDs, used to route in-order responses.
module id_fifo
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_MAX_OUTSTANDING,
   parameter int unsigned W     = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             head
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rptr];

   // Storage needs no reset: entries are only read while count says they are valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= next_ptr(wptr);
         if (do_pop)  rptr <= next_ptr(rptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port; responses routed back in order.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned NUM_PORTS       = DEF_NUM_PORTS,
   parameter int unsigned ADDR_W          = DEF_ADDR_W,
   parameter int unsigned DATA_W          = DEF_DATA_W,
   parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                              clk,
   input  logic                              reset,
   mem_arbiter_if.slave                      bus,
   output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
   output logic                              err
);
   localparam int unsigned ID_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int unsigned STRB_W = DATA_W / 8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wen;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } req_t;

   logic [ID_W-1:0]      rr_ptr;
   logic [ID_W-1:0]      grant;
   logic [ID_W-1:0]      head;
   logic                 any_valid;
   logic                 full;
   logic                 empty;
   logic                 issue;
   logic                 accept;
   logic                 resp_fire;
   req_t                 sel;
   logic [NUM_PORTS-1:0] ready;
   logic [NUM_PORTS-1:0] rvalid;

   assign any_valid = |bus.req_valid;
   assign grant     = ID_W'(rr_pick(MAX_PORTS'(bus.req_valid), PICK_W'(rr_ptr), NUM_PORTS));

   // Full is registered state only, so a same-cycle response never opens a slot
   assign issue     = reset && any_valid && !full;
   assign accept    = issue && bus.mem_req_ready;
   assign resp_fire = reset && bus.mem_resp_valid && !empty;

   always_comb begin
      sel = '0;
      if (any_valid) begin
         sel.addr  = bus.req_addr[grant*ADDR_W +: ADDR_W];
         sel.wen   = bus.req_wen[grant];
         sel.wdata = bus.req_wdata[grant*DATA_W +: DATA_W];
         sel.wstrb = bus.req_wstrb[grant*STRB_W +: STRB_W];
      end
   end

   always_comb begin
      ready = '0;
      if (accept) ready[grant] = 1'b1;
   end

   always_comb begin
      rvalid = '0;
      if (resp_fire) rvalid[head] = 1'b1;
   end

   assign bus.mem_req_valid = issue;
   assign bus.mem_req_addr  = sel.addr;
   assign bus.mem_req_wen   = sel.wen;
   assign bus.mem_req_wdata = sel.wdata;
   assign bus.mem_req_wstrb = sel.wstrb;
   assign bus.req_ready     = ready;
   assign bus.resp_valid    = rvalid;
   assign bus.resp_rdata    = bus.mem_resp_rdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant == ID_W'(NUM_PORTS - 1)) ? '0 : grant + ID_W'(1);
      end
   end

   // A response with nothing outstanding is dropped and latched as an error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err <= 1'b0;
      end else if (bus.mem_resp_valid && empty) begin
         err <= 1'b1;
      end
   end

   id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .W     (ID_W)
   ) u_id_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (accept),
      .pop   (resp_fire),
      .din   (grant),
      .full  (full),
      .empty (empty),
      .count (outstanding),
      .head  (head)
   );
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port among NUM_PORTS requesters (instruction/data ports of several control/data path pairs in a multi-core build).
- Round-robin arbitration on the request channel.
- In-order response routing through a tag FIFO of requester IDs.
- Bounded outstanding count; sticky error flag for protocol violations.

Parameters:
- NUM_PORTS, 2: number of requester ports (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width; byte strobe width is DATA_W/8.
- MAX_OUTSTANDING, 4: tag FIFO depth; must be a power of two, at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port request accepted.
- req_addr  in  NUM_PORTS*ADDR_W  per-port address, packed with port 0 in the LSBs.
- req_wen  in  NUM_PORTS  per-port write enable (1=store).
- req_wdata  in  NUM_PORTS*DATA_W  per-port write data.
- req_wstrb  in  NUM_PORTS*DATA_W/8  per-port byte strobes.
- resp_valid  out  NUM_PORTS  per-port response valid, one cycle.
- resp_rdata  out  DATA_W  response data, broadcast to all ports; qualified by resp_valid.
- mem_req_valid  out  1  downstream request valid.
- mem_req_ready  in  1  downstream accepts request.
- mem_req_addr  out  ADDR_W
- mem_req_wen  out  1
- mem_req_wdata  out  DATA_W
- mem_req_wstrb  out  DATA_W/8
- mem_resp_valid  in  1  downstream response, in request order, one per request (reads and writes).
- mem_resp_rdata  in  DATA_W
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  accepted-but-unanswered count.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0, asynchronous): rr_ptr=0, FIFO empty, outstanding=0, err=0. All ready/valid outputs are 0 while reset is held. In-flight downstream transactions are abandoned; the memory side must be reset together with this block.
- Grant (combinational): the first port with req_valid set, searching from rr_ptr upward and wrapping modulo NUM_PORTS. No grant when no port is valid.
- Downstream request: mem_req_valid = any req_valid && !full. mem_req_addr, mem_req_wen, mem_req_wdata and mem_req_wstrb are muxed from the granted port. When no port is granted they are driven to 0.
- Ready: req_ready[g] = mem_req_ready && !full for the granted port g; 0 for every other port. Zero-cycle request latency.
- Accept (mem_req_valid && mem_req_ready):
  - push g into the FIFO;
  - rr_ptr <= (g+1) mod NUM_PORTS;
  - rr_ptr is unchanged when no accept occurs.
- Fairness: a port holding req_valid is granted within NUM_PORTS accepts.
- Full: outstanding == MAX_OUTSTANDING. A pop in the same cycle does NOT free space for a push in that cycle (no combinational path from mem_resp_valid to mem_req_valid).
- Response (mem_resp_valid && !empty): resp_valid[head]=1 for exactly that cycle, resp_rdata = mem_resp_rdata, then pop. Zero-cycle response latency. Ports have no response back-pressure and must always sink responses.
- Simultaneous accept and response: push and pop both occur and outstanding is unchanged. Also legal when outstanding == 1 (response belongs to the older request).
- Error: mem_resp_valid while empty sets err=1 (sticky until reset). The response is dropped, all resp_valid stay 0, and outstanding stays 0.
- Pointer wrap: FIFO read/write pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally. Count is tracked separately.
- Requesters must hold req_valid and request fields stable until req_ready. A requester that drops req_valid early is simply skipped by the search.

Decomposition:
- Shared package mem_pkg:
  - request/response structs (addr, wen, wdata, wstrb / rdata);
  - port-ID typedef sized by $clog2(NUM_PORTS);
  - function rr_pick(valid, ptr).
- Sub-module id_fifo: synchronous FIFO (parameters DEPTH and W). Interface: push, pop, full, empty, count, head. Uses the same clk and reset.
- mem_arbiter holds the arbiter, muxes, and error logic.

Test Plan:
- Reset: hold reset=0 with all req_valid=1 -> req_ready=0, mem_req_valid=0, outstanding=0, err=0. Release reset -> port 0 is granted first.
- Round-robin: NUM_PORTS=2, both ports valid, mem_req_ready=1 every cycle -> grants alternate 0,1,0,1. Single-cycle responses return to ports 0,1,0,1 with matching rdata (0xA0,0xB1,...).
- Full: MAX_OUTSTANDING=4, mem_resp_valid=0 -> 4 accepts, then mem_req_valid=0 and outstanding=4. One response -> resp_valid[head]=1, outstanding=3. The next cycle a new accept occurs.
- Simultaneous push and pop at outstanding=4 -> no push in that cycle; outstanding goes to 3. At outstanding=2 -> push and pop together, outstanding stays 2.
- Back-pressure: mem_req_ready=0 for 5 cycles with port 1 valid -> req_ready=0, rr_ptr unchanged, request fields held on mem_req_*. mem_req_ready=1 -> single accept.
- Spurious response with outstanding=0: mem_resp_valid=1 -> err=1 and stays 1 afterwards, no resp_valid. reset=0 -> err=0.
